// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Header is a little-endian 16-bit word count.
    localparam int HDR_BYTES      = 2;
    // Bytes packed into one 32-bit instruction.
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// The word output already includes the byte being accepted this cycle, so the
// parent can capture a complete word on the same edge that word_full is high.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  byte_cnt_reg;
    logic [31:0] word_reg;

    // Each lane takes the incoming byte only when it is the lane being filled.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word[gi*8 +: 8] = (accept && (byte_cnt_reg == 2'(gi)))
                                     ? data : word_reg[gi*8 +: 8];
        end
    endgenerate

    assign word_full = accept && (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));

    // Advance the byte counter (wrapping after lane 3) and latch each accepted byte.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt_reg <= 2'd0;
            word_reg     <= 32'd0;
        end else if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            word_reg     <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: reads a word-count header and a
// little-endian byte stream, writes one 32-bit word per four bytes, and holds
// the CPU in reset for the duration of the load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W + 1)'(MEM_DEPTH);

    state_t             state_reg;
    state_t             state_next;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W:0]     word_idx_reg;
    logic [LEN_W:0]     word_idx_inc;
    logic [LEN_W-1:0]   len_full;
    logic               accept;
    logic               start_ok;
    logic               len_zero;
    logic               len_over;
    logic               last_word;
    logic               pack_accept;
    logic [31:0]        packed_word;
    logic               word_full;

    assign in_ready     = (state_reg == ST_LEN_LO) || (state_reg == ST_LEN_HI) ||
                          (state_reg == ST_DATA);
    assign wr_en        = (state_reg == ST_WRITE);
    assign accept       = in_valid && in_ready;
    assign start_ok     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    // High header byte combined with the low byte already captured.
    assign len_full     = {in_data, len_reg[7:0]};
    assign len_zero     = (len_full == '0);
    assign len_over     = ({1'b0, len_full} > DEPTH_EXT);
    assign word_idx_inc = word_idx_reg + 1'b1;
    assign last_word    = (word_idx_inc == {1'b0, len_reg});
    assign pack_accept  = accept && (state_reg == ST_DATA);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .accept    (pack_accept),
        .data      (in_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    // Next-state decision for the load sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start) state_next = ST_LEN_LO;
            ST_LEN_LO:        if (accept) state_next = ST_LEN_HI;
            ST_LEN_HI: begin
                if (accept) begin
                    if (len_zero)      state_next = ST_DONE;
                    else if (len_over) state_next = ST_IDLE;
                    else               state_next = ST_DATA;
                end
            end
            ST_DATA:          if (word_full) state_next = ST_WRITE;
            ST_WRITE:         state_next = last_word ? ST_DONE : ST_DATA;
            default:          state_next = ST_IDLE;
        endcase
    end

    // State, header/index counters and registered status/write outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            word_idx_reg <= '0;
            wr_addr      <= 32'd0;
            wr_data      <= 32'd0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cpu_hold     <= 1'b1;
                        word_idx_reg <= '0;
                        len_reg      <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) len_reg[7:0] <= in_data;
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_reg <= len_full;
                        if (len_zero) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (len_over) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    // Capture the word and its address so they stay stable in WRITE and after.
                    if (word_full) begin
                        wr_data <= packed_word;
                        wr_addr <= 32'({word_idx_reg, 2'b00});
                    end
                end
                ST_WRITE: begin
                    word_idx_reg <= word_idx_inc;
                    if (last_word) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory, the write-side counterpart to the read-only combinational instruction memory.
- Accepts a byte stream over a valid/ready handshake.
- Decodes a 16-bit word-count header, then packs little-endian bytes into 32-bit instructions.
- Issues one write per word into the memory's write port.
- Holds the CPU in reset until the image is fully loaded.

Parameters:
- MEM_DEPTH, 256: number of 32-bit words in the target instruction memory; the maximum legal word count.
- LEN_W, 16: width of the word-count header. Fixed at 16; the header is always two bytes.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load. Sampled only in IDLE or DONE.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  32  byte address of the write; always word-aligned (bits [1:0] = 0).
- wr_data  output  32  instruction word to write.
- cpu_hold  output  1  keeps the CPU in reset while a load is in progress.
- done  output  1  load completed successfully.
- err  output  1  header word count exceeded MEM_DEPTH.

Behaviour:
- Reset values: state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0. All internal counters are 0.
- Handshake: a byte is consumed only in a cycle where in_valid && in_ready. When in_ready=0 the source holds its byte; nothing is dropped.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE.
- IDLE/DONE + start:
  - go to LEN_LO; clear done and err; set cpu_hold=1.
  - reset word_idx and byte_cnt to 0.
- LEN_LO:
  - in_ready=1; on accept, len[7:0]=in_data; go to LEN_HI.
- LEN_HI:
  - in_ready=1; on accept, len[15:8]=in_data.
  - Next-state decision uses the full 16-bit len, including the byte just accepted:
    - len==0 -> DONE.
    - len>MEM_DEPTH -> IDLE with err=1 and cpu_hold=0. No writes are issued.
    - otherwise -> DATA.
- DATA:
  - in_ready=1. Accepted byte k (byte_cnt=k, 0..3) goes into wr_data[8k+7:8k], little-endian.
  - byte_cnt increments on each accept.
  - On accepting byte 3 -> WRITE; byte_cnt wraps to 0.
- WRITE:
  - lasts exactly one cycle; wr_en=1, in_ready=0, wr_addr = word_idx*4, wr_data holds the packed word.
  - Next cycle: word_idx+1; if word_idx+1 == len -> DONE, else DATA.
- Write latency: wr_en is high in the cycle immediately after the 4th byte of a word is accepted.
- wr_addr and wr_data hold their last values outside WRITE. Consumers must qualify them with wr_en.
- DONE: done=1 and cpu_hold=0, held until the next start or rst. in_ready=0; extra stream bytes are not consumed.
- start in LEN_LO/LEN_HI/DATA/WRITE is ignored.
- err is sticky until the next start or rst.
- Reset mid-load: immediate return to reset values. A partially packed word is never written. Words already written stay in memory.
- Width rules:
  - word_idx is LEN_W+1 bits wide, so the compare against len cannot wrap.
  - len==MEM_DEPTH is legal; the last write address is (MEM_DEPTH-1)*4.
- Stall tolerance: in_valid gaps of any length in any accepting state have no effect other than delaying progress.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum type (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE);
  - localparam HDR_BYTES=2;
  - localparam BYTES_PER_WORD=4.
- One sub-module is natural: imem_word_packer. It is the byte-to-word shifter with a 2-bit byte_cnt. Inputs: accept strobe and byte. Outputs: packed word and a word_full pulse.
- The top level holds the FSM, length and index counters, and the output registers.

Test Plan:
- Reset then idle: assert rst 2 cycles, no start -> all outputs 0, in_ready=0, no wr_en over 20 cycles.
- Normal load, 2 words: start; bytes 02 00, 13 00 50 00, 93 00 10 00 with in_valid continuous -> two wr_en pulses:
  - addr 0x0, data 0x00500013;
  - addr 0x4, data 0x00100093;
  - then done=1 and cpu_hold=0.
- Stalled source: same stream with in_valid deasserted 3 cycles between every byte -> identical writes. Each wr_en is one cycle after the 4th accepted byte. in_ready=0 during WRITE.
- Length limits:
  - header 0x0101 (257) with MEM_DEPTH=256 -> err=1, zero writes, returns to IDLE.
  - header 0x0000 -> done=1, zero writes.
  - header 0x0100 with 1024 data bytes -> 256 writes, last addr 0x3FC.
- Reset mid-load: assert rst after 2 bytes of word 1 (word 0 already written) -> no further wr_en, all outputs at reset values. A new start plus a full stream loads correctly from addr 0.
- Restart from DONE: after a successful load, pulse start and send header 01 00 plus one word -> done clears, cpu_hold=1, exactly one write to addr 0x0, done=1 again.
